// File: rtl/adder_subtractor.sv
// Multi-cycle N-bit two's-complement adder/subtractor: STEP bits per clock, LSB first,
// through a STEP-bit ripple slice, behind a start/done handshake.
module adder_subtractor #(
  parameter int N    = 8,
  parameter int STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         addsub,
  input  logic         start,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         done,
  output logic [1:0]   o_state
);

  localparam int NSTEPS = N / STEP;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_opa;
  logic [N-1:0]    r_opb;
  logic            r_carry;
  logic [N-1:0]    r_res;
  logic [CW-1:0]   r_cnt;

  logic [STEP-1:0] w_sbits;
  logic            w_slice_cout;
  logic [N-1:0]    w_ins;
  logic [N-1:0]    w_res_next;
  logic            w_last;
  logic            w_accept;

  // Ripple slice over the low STEP bits of the shifting operands.
  always_comb begin : ripple
    logic c;
    c = r_carry;
    w_sbits = '0;
    for (int i = 0; i < STEP; i++) begin
      w_sbits[i] = r_opa[i] ^ r_opb[i] ^ c;
      c          = (r_opa[i] & r_opb[i]) | (c & (r_opa[i] ^ r_opb[i]));
    end
    w_slice_cout = c;
  end

  // New slice bits enter at the MSB end so the LSB-first result lands in place.
  assign w_ins      = N'(w_sbits);
  assign w_res_next = (r_res >> STEP) | (w_ins << (N - STEP));
  assign w_last     = (r_cnt == CW'(NSTEPS - 1));
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign o_state    = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_opa   <= A;
            r_opb   <= addsub ? ~B : B;
            r_carry <= addsub;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_res   <= w_res_next;
          r_opa   <= r_opa >> STEP;
          r_opb   <= r_opb >> STEP;
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            sum     <= w_res_next;
            cout    <= w_slice_cout;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed and randomized checks of adder_subtractor against an arithmetic reference model.
module tb_adder_subtractor;

  localparam int N    = 8;
  localparam int STEP = 2;
  localparam int LAT  = N / STEP + 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         addsub;
  logic         start;
  logic [N-1:0] sum;
  logic         cout;
  logic         done;
  logic [1:0]   o_state;

  int n_vec;
  int n_err;

  logic [N:0]   exp_q[$];
  logic [N-1:0] prev_sum;
  logic         prev_cout;

  adder_subtractor #(.N(N), .STEP(STEP)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .addsub  (addsub),
    .start   (start),
    .sum     (sum),
    .cout    (cout),
    .done    (done),
    .o_state (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic op);
    logic [N-1:0] s;
    logic         c;
    int           ai;
    int           bi;
    ai = int'(a);
    bi = int'(b);
    if (op) begin
      s = N'(ai - bi);
      c = (ai >= bi);
    end else begin
      s = N'(ai + bi);
      c = ((ai + bi) >= (1 << N));
    end
    return {c, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge; issues one request, returns at the negedge where done is seen.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic op);
    logic [N:0] e;
    int lat;
    A      = a;
    B      = b;
    addsub = op;
    start  = 1'b1;
    exp_q.push_back(model(a, b, op));
    @(negedge clk);
    start = 1'b0;
    A     = N'($urandom);
    B     = N'($urandom);
    chk("done_early", 32'(done), 32'd0);
    chk("sum_held_at_accept", 32'(sum), 32'(prev_sum));
    chk("cout_held_at_accept", 32'(cout), 32'(prev_cout));
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sum", 32'(sum), 32'(e[N-1:0]));
      chk("cout", 32'(cout), 32'(e[N]));
      prev_sum  = e[N-1:0];
      prev_cout = e[N];
    end else begin
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end
  endtask

  initial begin
    int dcount;
    logic [N:0] e;
    n_vec = 0;
    n_err = 0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    rst    = 1'b0;
    A      = '0;
    B      = '0;
    addsub = 1'b0;
    start  = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_state_idle", 32'(o_state), 32'd0);
    @(negedge clk);

    run_op(8'h80, 8'h80, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hC8, 8'h32, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(o_state), 32'd0);
    chk("sum_hold_idle", 32'(sum), 32'h00FA);

    rst = 1'b0;
    #1;
    chk("idle_reset_sum", 32'(sum), 32'd0);
    chk("idle_reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    prev_sum  = '0;
    prev_cout = 1'b0;
    @(negedge clk);

    run_op(8'h55, 8'h33, 1'b0);
    run_op(8'hAA, 8'h0F, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    chk("done_one_cycle_2", 32'(done), 32'd0);
    chk("sum_hold_2", 32'(sum), 32'h0080);

    // start re-asserted with other operands during BUSY must be ignored
    A = 8'h12; B = 8'h34; addsub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'hEE; B = 8'hEE; addsub = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_done", 32'(done), 32'd1);
    e = exp_q.pop_front();
    chk("busy_start_sum", 32'(sum), 32'(e[N-1:0]));
    chk("busy_start_cout", 32'(cout), 32'(e[N]));
    prev_sum  = e[N-1:0];
    prev_cout = e[N];
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("busy_start_single_done", 32'(dcount), 32'd0);

    // Reset in the middle of BUSY aborts without a done pulse
    A = 8'h10; B = 8'h20; addsub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_state", 32'(o_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    prev_sum  = '0;
    prev_cout = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);

    // Randomized back-to-back requests, each accepted from the DONE cycle
    for (int i = 0; i < 40; i++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    chk("final_done_low", 32'(done), 32'd0);
    chk("final_idle", 32'(o_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
Name: adder_subtractor

Overview:
- Multi-cycle N-bit two's-complement adder/subtractor.
- A start pulse captures both operands and the operation. The block then processes STEP bits per clock, LSB first, through a small ripple slice.
- On completion it presents the N-bit result and carry-out and pulses done.
- Used as a low-area arithmetic unit behind a simple start/done handshake.

Parameters:
- N, 8, operand and result width; must be a positive multiple of STEP.
- STEP, 2, bits processed per clock. Busy phase lasts N/STEP cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- A  input  N  operand A; sampled only when start is accepted.
- B  input  N  operand B; sampled only when start is accepted.
- addsub  input  1  operation select, sampled with the operands: 0 = A+B, 1 = A-B.
- start  input  1  request; accepted on a rising edge when the block is in IDLE or DONE.
- sum  output  N  result; registered, holds its value until the next accepted start.
- cout  output  1  carry out of bit N-1; registered, holds like sum.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; sum=0, cout=0, done=0; internal operand, carry and count registers cleared.
  - Reset mid-operation aborts the computation; no done pulse is produced for it.
- States: IDLE, BUSY, DONE.
- IDLE, or DONE, with start=1 at a clock edge (accept):
  - Load opA=A.
  - Load opB = B when addsub=0, or ~B when addsub=1.
  - Load carry=addsub.
  - Clear the result shift register; count=0; done=0; go to BUSY.
  - The registered sum and cout outputs are not changed at accept.
- IDLE with start=0: stay in IDLE.
- BUSY, each cycle:
  - Add the low STEP bits of opA and opB plus carry through a STEP-bit ripple slice.
  - Shift the STEP result bits into the result register from the MSB side.
  - Shift opA and opB right by STEP; carry takes the slice carry-out; count increments.
- BUSY, when count reaches N/STEP-1:
  - In that cycle, the final slice completes.
  - sum takes the full result; cout takes the final carry.
  - done=1 for the next cycle; state goes to DONE.
- DONE lasts one cycle:
  - done=0 afterwards, with sum and cout held.
  - Returns to IDLE, unless start=1 at that edge, in which case it accepts as from IDLE.
- start while BUSY is ignored: no restart and no operand re-capture.
- Latency: accept edge, then N/STEP busy edges; done is high during the cycle after the last busy edge. For N=8, STEP=2: done is high in cycle 5 after the accept edge.
  - Back-to-back requests spaced 8 cycles apart are always serviced.
- Arithmetic:
  - sum = (A + (addsub ? ~B+1 : B)) mod 2^N.
  - cout = carry out of bit N-1 of A + (B or ~B) + addsub.
  - For subtraction, cout=1 means no borrow (A >= B unsigned).
  - No overflow flag is produced.
- Wrap-around: results exceeding N bits wrap modulo 2^N, with cout reporting the carry.

Test Plan:
- rst=0 for 3 cycles, then release -> sum=0, cout=0, done=0, state IDLE; the first start afterwards is accepted normally.
- A=0x80, B=0x80, addsub=1, start for 1 cycle -> done pulse 5 cycles after accept; sum=0x00, cout=1.
- A=0xFF, B=0x01, addsub=0 -> sum=0x00, cout=1 (wrap); A=0xC8, B=0x32, addsub=0 -> sum=0xFA, cout=0.
- rst pulsed low for 1 cycle while idle after a result -> sum/cout cleared to 0. Then A=0x55, B=0x33, add -> sum=0x88, cout=0.
- A=0xAA, B=0x0F, addsub=1 -> sum=0x9B, cout=1; then A=0x7F, B=0x01, add -> sum=0x80, cout=0. done is exactly one cycle wide each time.
- start re-asserted during BUSY with different operands -> ignored; original result and a single done pulse. rst asserted mid-BUSY -> no done pulse, outputs 0.
